// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth multiplier sequencer: operand
// width, fixed core latency and the controller state codes.
package booth_pkg;

    localparam int BOOTH_WIDTH   = 32;
    localparam int BOOTH_LATENCY = 48;

    // Controller state codes, kept as plain 3-bit constants so they stay
    // compatible with older tooling and waveform decoders.
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] CLR  = 3'd1;
    localparam logic [2:0] LOAD = 3'd2;
    localparam logic [2:0] RUN  = 3'd3;
    localparam logic [2:0] CAPT = 3'd4;
    localparam logic [2:0] DONE = 3'd5;

endpackage

// File: rtl/booth_mult_ctrl_if.sv
// Bundle of the operand/result handshakes and the multiplier core pins seen
// by booth_mult_ctrl. The slave modport is the controller's view; the master
// modport is the view of the upstream source, downstream sink and core.
interface booth_mult_ctrl_if #(
    parameter int WIDTH = 32
);
    logic                 i_valid;
    logic                 o_ready;
    logic [WIDTH-1:0]     i_inputA;
    logic [WIDTH-1:0]     i_inputB;
    logic                 o_valid;
    logic                 i_ready;
    logic [2*WIDTH-1:0]   o_result;
    logic                 o_busy;
    logic                 o_mult_rst;
    logic                 o_mult_load;
    logic [WIDTH-1:0]     o_multiplicand;
    logic [WIDTH-1:0]     o_multiplier;
    logic [2*WIDTH-1:0]   i_mult_product;

    modport slave (
        input  i_valid, i_inputA, i_inputB, i_ready, i_mult_product,
        output o_ready, o_valid, o_result, o_busy,
               o_mult_rst, o_mult_load, o_multiplicand, o_multiplier
    );

    modport master (
        output i_valid, i_inputA, i_inputB, i_ready, i_mult_product,
        input  o_ready, o_valid, o_result, o_busy,
               o_mult_rst, o_mult_load, o_multiplicand, o_multiplier
    );
endinterface

// File: rtl/lat_down_counter.sv
// Loadable down-counter that times the multiplier core's fixed compute
// window. Saturates at zero and flags when it gets there.
module lat_down_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);
    logic [CNT_W-1:0] cnt_reg;

    // Load has priority over decrement; never wrap below zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (dec && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign zero = (cnt_reg == '0);
endmodule

// File: rtl/booth_mult_ctrl.sv
// Sequencer and result-capture stage for the sequential radix-4 Booth core.
// Accepts one signed operand pair, clears then loads the core, holds the
// operands for the whole compute window, captures the product and offers it
// downstream. Optional macro BOOTH_CTRL_ZERO_BYPASS_EN short-circuits
// operations with a zero operand straight to a zero result.
module booth_mult_ctrl
    import booth_pkg::*;
#(
    parameter int WIDTH   = BOOTH_WIDTH,
    parameter int LATENCY = BOOTH_LATENCY,
    parameter int CNT_W   = 6
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    booth_mult_ctrl_if.slave       bus
);
    localparam logic [CNT_W-1:0] RUN_LOAD = CNT_W'(LATENCY - 1);

    logic [2:0]           state_reg, state_next;
    logic [WIDTH-1:0]     opa_reg, opb_reg;
    logic [2*WIDTH-1:0]   result_reg;
    logic                 accept;
    logic                 cnt_zero;
    logic                 zero_op;

    assign accept = bus.i_valid && (state_reg == IDLE);

`ifdef BOOTH_CTRL_ZERO_BYPASS_EN
    assign zero_op = (bus.i_inputA == '0) || (bus.i_inputB == '0);
`else
    assign zero_op = 1'b0;
`endif

    // Next-state logic: one cycle per state except RUN (timed) and DONE (held).
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = zero_op ? DONE : CLR;
            CLR:  state_next = LOAD;
            LOAD: state_next = RUN;
            RUN:  if (cnt_zero) state_next = CAPT;
            CAPT: state_next = DONE;
            DONE: if (bus.i_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register; reset abandons any operation in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Operand registers feed the core directly and stay put until next accept.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            opa_reg <= '0;
            opb_reg <= '0;
        end else if (accept) begin
            opa_reg <= bus.i_inputA;
            opb_reg <= bus.i_inputB;
        end
    end

    // Result capture; value persists after the output handshake.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            result_reg <= '0;
        end else if (state_reg == CAPT) begin
            result_reg <= bus.i_mult_product;
        end else if (accept && zero_op) begin
            result_reg <= '0;
        end
    end

    lat_down_counter #(
        .CNT_W    (CNT_W)
    ) u_lat_cnt (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .load     (state_reg == LOAD),
        .load_val (RUN_LOAD),
        .dec      (state_reg == RUN),
        .zero     (cnt_zero)
    );

    // The core clear also follows our own reset so the core never holds a
    // stale accumulator across a controller reset.
    assign bus.o_mult_rst     = ~i_rst_n | (state_reg == CLR);
    assign bus.o_mult_load    = (state_reg == LOAD);
    assign bus.o_multiplicand = opa_reg;
    assign bus.o_multiplier   = opb_reg;
    assign bus.o_ready        = (state_reg == IDLE);
    assign bus.o_busy         = (state_reg != IDLE);
    assign bus.o_valid        = (state_reg == DONE);
    assign bus.o_result       = result_reg;
endmodule

// File: tb/tb_booth_mult_ctrl.sv
// Self-checking bench for booth_mult_ctrl: random and directed operand pairs,
// a behavioural multiplier core, a scoreboard of expected products/latencies
// and a pin monitor for the core clear/load timing and operand stability.
module tb_booth_mult_ctrl;
    localparam int W   = 32;
    localparam int LAT = 48;
`ifdef BOOTH_CTRL_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    booth_mult_ctrl_if #(.WIDTH(W)) bif();

    booth_mult_ctrl dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bif.slave)
    );

    typedef struct {
        logic [63:0] prod;
        int          t;
        int          lat;
        int          hold;
    } exp_t;

    exp_t sb[$];
    int   last_t = 0;
    int   txn = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint x, y;
        x = longint'($signed(a));
        y = longint'($signed(b));
        return 64'(x * y);
    endfunction

    // Behavioural core: clear on rst, accumulate a*b (live operands) LAT
    // cycles after load.
    logic [63:0] core_acc = 64'd0;
    int          core_cnt = 0;
    always @(posedge clk) begin
        if (bif.o_mult_rst) begin
            core_acc <= 64'd0;
            core_cnt <= 0;
        end else if (bif.o_mult_load) begin
            core_cnt <= LAT;
        end else if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1)
                core_acc <= core_acc + ref_mul(bif.o_multiplicand, bif.o_multiplier);
        end
    end
    assign bif.i_mult_product = core_acc;

    // Pin monitor: clear/load pulses relative to the handshake, operand hold.
    int          pm_hs = 0;
    logic [31:0] pm_a = '0, pm_b = '0;
    bit          pm_act = 1'b0, pm_byp = 1'b0;
    int          pm_d = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pm_act = 1'b0;
            end else begin
                if (pm_act && cyc > pm_hs) begin
                    pm_d = cyc - pm_hs;
                    check("mult_rst", 64'(bif.o_mult_rst), 64'(!pm_byp && pm_d == 1));
                    check("mult_load", 64'(bif.o_mult_load), 64'(!pm_byp && pm_d == 2));
                    if (!pm_byp && pm_d <= LAT + 3) begin
                        check("multiplicand", 64'(bif.o_multiplicand), 64'(pm_a));
                        check("multiplier", 64'(bif.o_multiplier), 64'(pm_b));
                    end
                end else if (!pm_act) begin
                    check("idle_mult_rst", 64'(bif.o_mult_rst), 64'd0);
                    check("idle_mult_load", 64'(bif.o_mult_load), 64'd0);
                end
                if (bif.i_valid && bif.o_ready) begin
                    pm_hs  = cyc;
                    pm_a   = bif.i_inputA;
                    pm_b   = bif.i_inputB;
                    pm_act = 1'b1;
                    pm_byp = BYP && (bif.i_inputA == 0 || bif.i_inputB == 0);
                end
            end
        end
    end

    // Output monitor: pops the scoreboard on each result presented.
    initial begin
        exp_t e;
        bif.i_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bif.o_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", 64'd1, 64'd0);
                    bif.i_ready = 1'b1;
                    @(posedge clk);
                    #1 bif.i_ready = 1'b0;
                end else begin
                    e = sb.pop_front();
                    txn++;
                    $display("txn %0d: result %h latency %0d hold %0d", txn, bif.o_result, cyc - e.t, e.hold);
                    check("latency", 64'(cyc - e.t), 64'(e.lat));
                    check("result", bif.o_result, e.prod);
                    check("busy_done", 64'(bif.o_busy), 64'd1);
                    for (int i = 0; i < e.hold; i++) begin
                        @(negedge clk);
                        check("hold_valid", 64'(bif.o_valid), 64'd1);
                        check("hold_result", bif.o_result, e.prod);
                        check("hold_ready", 64'(bif.o_ready), 64'd0);
                    end
                    bif.i_ready = 1'b1;
                    @(posedge clk);
                    #1 bif.i_ready = 1'b0;
                    @(negedge clk);
                    check("valid_drop", 64'(bif.o_valid), 64'd0);
                    check("result_kept", bif.o_result, e.prod);
                end
            end
        end
    end

    // Present one operand pair and hold it until accepted.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int hold);
        exp_t e;
        int   n;
        bit   ok;
        @(posedge clk);
        #1;
        bif.i_valid  = 1'b1;
        bif.i_inputA = a;
        bif.i_inputB = b;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 300) begin
            @(negedge clk);
            if (bif.o_ready) ok = 1'b1;
            else n++;
        end
        if (!ok) begin
            check("ready_timeout", 64'd0, 64'd1);
        end else begin
            e.prod = ref_mul(a, b);
            e.t    = cyc;
            e.lat  = (BYP && (a == 0 || b == 0)) ? 1 : LAT + 4;
            e.hold = hold;
            last_t = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bif.i_valid  = 1'b0;
        bif.i_inputA = $urandom;
        bif.i_inputB = $urandom;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a, b;
        int          n;
        bif.i_valid  = 1'b0;
        bif.i_inputA = '0;
        bif.i_inputB = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(bif.o_valid), 64'd0);
        check("rst_result", bif.o_result, 64'd0);
        check("rst_mult_rst", 64'(bif.o_mult_rst), 64'd1);
        check("rst_mult_load", 64'(bif.o_mult_load), 64'd0);
        check("rst_busy", 64'(bif.o_busy), 64'd0);
        check("rst_ready", 64'(bif.o_ready), 64'd1);
        check("rst_multiplicand", 64'(bif.o_multiplicand), 64'd0);
        rst_n = 1'b1;

        do_op(32'd3, 32'd5, 0);
        do_op(32'hFFFFFFF9, 32'd6, 0);

        // Back-to-back with a stalled sink; second op proves the core clear.
        do_op(32'h00012345, 32'hFFFF0000, 10);
        do_op(32'h7FFFFFFF, 32'h7FFFFFFF, 0);

        // Reset in the middle of a compute window.
        do_op(32'd1000, 32'd77, 0);
        while (cyc < last_t + 20) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(bif.o_valid), 64'd0);
        check("midrst_result", bif.o_result, 64'd0);
        check("midrst_mult_rst", 64'(bif.o_mult_rst), 64'd1);
        check("midrst_busy", 64'(bif.o_busy), 64'd0);
        check("midrst_ready", 64'(bif.o_ready), 64'd1);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        do_op(32'd2, 32'hFFFFFFFD, 0);

        do_op(32'd0, 32'd123, 1);

        // Most-negative squared; extra valid during RUN must be ignored.
        do_op(32'h80000000, 32'h80000000, 2);
        repeat (10) @(posedge clk);
        #1;
        bif.i_valid  = 1'b1;
        bif.i_inputA = $urandom;
        bif.i_inputB = $urandom;
        repeat (5) begin
            @(negedge clk);
            check("ready_while_busy", 64'(bif.o_ready), 64'd0);
        end
        @(posedge clk);
        #1 bif.i_valid = 1'b0;

        for (int k = 0; k < 24; k++) begin
            a = $urandom;
            b = $urandom;
            n = $urandom_range(0, 7);
            if (n == 0) a = '0;
            if (n == 1) b = '0;
            do_op(a, b, $urandom_range(0, 3));
        end

        n = 0;
        while ((sb.size() != 0 || bif.o_busy) && n < 500) begin
            @(posedge clk);
            n++;
        end
        check("drain", 64'(sb.size() == 0 && !bif.o_busy), 64'd1);
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
